// File: rtl/rvb_issue.sv
// rvb_issue: issue stage in front of the bitmanip ALU.
// Validates the major opcode and substitutes the ADDIWU immediate for rs2.
// It also extracts the instruction bits the ALU consumes, and presents the
// result through a 2-entry skid buffer so that in_ready comes from a register.
// Optional build macro RVB_ISSUE_STATS_EN adds issue/stall/illegal counters.
module rvb_issue #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs3,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_rs3,
  output logic            out_insn3,
  output logic            out_insn5,
  output logic            out_insn12,
  output logic            out_insn13,
  output logic            out_insn14,
  output logic            out_insn25,
  output logic            out_insn26,
  output logic            out_insn27,
  output logic            out_insn30,
  output logic            illegal,
  output logic [31:0]     illegal_insn
`ifdef RVB_ISSUE_STATS_EN
  ,
  output logic [31:0]     stat_issued,
  output logic [31:0]     stat_stall,
  output logic [15:0]     stat_illegal
`endif
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic [8:0]      bits;  // {i3,i5,i12,i13,i14,i25,i26,i27,i30}
  } ent_t;

  // Occupancy of the head/skid pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        vld_q, vld_d;
  ent_t        head_q, head_d;
  ent_t        skid_q, skid_d;
  logic        ill_q, ill_d;
  logic [31:0] ill_insn_q, ill_insn_d;

  logic        is_op_s, is_op32_s, is_addiwu_s, legal_s;
  logic        in_fire_s, out_fire_s, push_s, rej_s;
  ent_t        new_ent_s;

  // Reset forces both handshakes low even before the first reset edge.
  assign in_ready  = rdy_q & ~reset;
  assign out_valid = vld_q & ~reset;

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // Opcode check and operand/bit extraction for the offered word.
  always_comb begin
    is_op_s     = (in_insn[6:0] == OPC_OP);
    is_op32_s   = (in_insn[6:0] == OPC_OP32);
    is_addiwu_s = (in_insn[6:0] == OPC_OPIMM32) && (in_insn[14:12] == 3'b100);
    legal_s     = (in_insn[1:0] == 2'b11) &&
                  (is_op_s || ((XLEN == 64) && (is_op32_s || is_addiwu_s)));
    push_s      = in_fire_s & legal_s;
    rej_s       = in_fire_s & ~legal_s;
    new_ent_s.rs1  = in_rs1;
    new_ent_s.rs3  = in_rs3;
    if (is_addiwu_s) begin
      new_ent_s.rs2 = {{(XLEN-12){in_insn[31]}}, in_insn[31:20]};
    end else begin
      new_ent_s.rs2 = in_rs2;
    end
    new_ent_s.bits = {in_insn[3], in_insn[5], in_insn[12], in_insn[13], in_insn[14],
                      in_insn[25], in_insn[26], in_insn[27], in_insn[30]};
  end

  // Buffer next-state: head always drives the outputs, skid absorbs one extra.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          head_d  = new_ent_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && out_fire_s) begin
          head_d  = new_ent_s;
          state_d = ST_ONE;
        end else if (push_s) begin
          skid_d  = new_ent_s;
          state_d = ST_FULL;
        end else if (out_fire_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_fire_s) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    rdy_d      = (state_d != ST_FULL);
    vld_d      = (state_d != ST_EMPTY);
    ill_d      = rej_s;
    ill_insn_d = rej_s ? in_insn : ill_insn_q;
  end

  // Control state and illegal reporting, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      rdy_q      <= 1'b1;
      vld_q      <= 1'b0;
      ill_q      <= 1'b0;
      ill_insn_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      vld_q      <= vld_d;
      ill_q      <= ill_d;
      ill_insn_q <= ill_insn_d;
    end
  end

  // Payload registers carry no reset; validity comes from the control state.
  always_ff @(posedge clock) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign out_rs1      = head_q.rs1;
  assign out_rs2      = head_q.rs2;
  assign out_rs3      = head_q.rs3;
  assign {out_insn3, out_insn5, out_insn12, out_insn13, out_insn14,
          out_insn25, out_insn26, out_insn27, out_insn30} = head_q.bits;
  assign illegal      = ill_q;
  assign illegal_insn = ill_insn_q;

`ifdef RVB_ISSUE_STATS_EN
  logic [31:0] issued_q, stall_q;
  logic [15:0] sill_q;

  // Free-running wrap-around statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q <= 32'd0;
      stall_q  <= 32'd0;
      sill_q   <= 16'd0;
    end else begin
      issued_q <= issued_q + {31'd0, out_fire_s};
      stall_q  <= stall_q + {31'd0, (out_valid & ~out_ready)};
      sill_q   <= sill_q + {15'd0, rej_s};
    end
  end

  assign stat_issued  = issued_q;
  assign stat_stall   = stall_q;
  assign stat_illegal = sill_q;
`endif

endmodule

// File: tb/tb_rvb_issue.sv
// Randomized and directed bench for rvb_issue against a queue-based model.
module tb_rvb_issue;
  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_rs1, in_rs2, in_rs3;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_rs1, out_rs2, out_rs3;
  logic            out_insn3, out_insn5, out_insn12, out_insn13, out_insn14;
  logic            out_insn25, out_insn26, out_insn27, out_insn30;
  logic            illegal;
  logic [31:0]     illegal_insn;
`ifdef RVB_ISSUE_STATS_EN
  logic [31:0]     stat_issued, stat_stall;
  logic [15:0]     stat_illegal;
`endif

  always #5 clock = ~clock;

  rvb_issue #(.XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_insn3(out_insn3), .out_insn5(out_insn5), .out_insn12(out_insn12),
    .out_insn13(out_insn13), .out_insn14(out_insn14), .out_insn25(out_insn25),
    .out_insn26(out_insn26), .out_insn27(out_insn27), .out_insn30(out_insn30),
    .illegal(illegal), .illegal_insn(illegal_insn)
`ifdef RVB_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall), .stat_illegal(stat_illegal)
`endif
  );

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic [31:0] insn;
  } ent_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        mq[$];
  logic        m_ill;
  logic [31:0] m_ill_insn;
  logic [31:0] m_issued, m_stall;
  logic [15:0] m_sill;
  logic        last_in_fire;
  int          n_dut_out;
  logic [63:0] dut_log[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_legal(input logic [31:0] w);
    if (w[1:0] != 2'b11) return 1'b0;
    if (w[6:0] == 7'h33) return 1'b1;
    if (XLEN == 64 && w[6:0] == 7'h3B) return 1'b1;
    if (XLEN == 64 && w[6:0] == 7'h1B && w[14:12] == 3'b100) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_rs2(input logic [31:0] w, input logic [63:0] rs2);
    logic signed [63:0] imm;
    imm = 64'($signed(w[31:20]));
    return (w[6:0] == 7'h1B) ? imm : rs2;
  endfunction

  function automatic logic [8:0] exp_bits(input logic [31:0] w);
    return {w[3], w[5], w[12], w[13], w[14], w[25], w[26], w[27], w[30]};
  endfunction

  function automatic logic [31:0] pick_insn();
    case ($urandom_range(0, 7))
      0: return 32'h40007033;
      1: return 32'h0000703B;
      2: return 32'hFFF0C01B;
      3: return 32'h1230C01B;
      4: return 32'h00000013;
      5: return 32'h0000001B;
      6: return 32'h00000032;
      default: return $urandom;
    endcase
  endfunction

  // Compare all visible DUT outputs against the model state.
  task automatic check_outputs();
    logic m_rdy, m_vld;
    m_rdy = reset ? 1'b0 : (mq.size() != 2);
    m_vld = reset ? 1'b0 : (mq.size() != 0);
    check("in_ready", 64'(in_ready), 64'(m_rdy));
    check("out_valid", 64'(out_valid), 64'(m_vld));
    check("illegal", 64'(illegal), 64'(m_ill));
    check("illegal_insn", 64'(illegal_insn), 64'(m_ill_insn));
    if (m_vld && out_valid) begin
      check("out_rs1", 64'(out_rs1), mq[0].rs1);
      check("out_rs2", 64'(out_rs2), exp_rs2(mq[0].insn, mq[0].rs2));
      check("out_rs3", 64'(out_rs3), mq[0].rs3);
      check("out_bits", 64'({out_insn3, out_insn5, out_insn12, out_insn13, out_insn14,
                             out_insn25, out_insn26, out_insn27, out_insn30}),
            64'(exp_bits(mq[0].insn)));
    end
`ifdef RVB_ISSUE_STATS_EN
    check("stat_issued", 64'(stat_issued), 64'(m_issued));
    check("stat_stall", 64'(stat_stall), 64'(m_stall));
    check("stat_illegal", 64'(stat_illegal), 64'(m_sill));
`endif
  endtask

  // One clock cycle: check, advance the model with the driven inputs, clock.
  task automatic tick();
    logic m_rdy, m_vld, in_f, out_f;
    ent_t e;
    #1;
    check_outputs();
    if (out_valid && out_ready) begin
      dut_log.push_back(64'(out_rs1));
      n_dut_out++;
    end
    m_rdy = (mq.size() != 2);
    m_vld = (mq.size() != 0);
    if (reset) begin
      mq.delete();
      m_ill = 1'b0; m_ill_insn = 32'd0;
      m_issued = 32'd0; m_stall = 32'd0; m_sill = 16'd0;
      last_in_fire = 1'b0;
    end else begin
      in_f  = in_valid && m_rdy;
      out_f = m_vld && out_ready;
      if (m_vld && !out_ready) m_stall++;
      if (out_f) begin
        void'(mq.pop_front());
        m_issued++;
      end
      m_ill = 1'b0;
      if (in_f) begin
        if (is_legal(in_insn)) begin
          e.rs1 = 64'(in_rs1); e.rs2 = 64'(in_rs2); e.rs3 = 64'(in_rs3); e.insn = in_insn;
          mq.push_back(e);
        end else begin
          m_ill = 1'b1;
          m_ill_insn = in_insn;
          m_sill++;
        end
      end
      last_in_fire = in_f;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] r1,
                       input logic [63:0] r2, input logic ordy);
    in_valid  = v;
    in_insn   = w;
    in_rs1    = XLEN'(r1);
    in_rs2    = XLEN'(r2);
    in_rs3    = XLEN'({$urandom, $urandom});
    out_ready = ordy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] a_v, b_v, c_v;
    int rdy_low;
    reset = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b0);
    m_ill = 1'b0; m_ill_insn = 32'd0; m_issued = 32'd0; m_stall = 32'd0; m_sill = 16'd0;
    last_in_fire = 1'b0; n_dut_out = 0;
    repeat (2) @(negedge clock);
    tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_illegal_insn", 64'(illegal_insn), 64'd0);

    // Single OP word.
    drive(1'b1, 32'h40007033, 64'hF0, 64'h3C, 1'b1);
    tick();
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    check("op_valid", 64'(out_valid), 64'd1);
    check("op_rs1", 64'(out_rs1), 64'hF0);
    check("op_rs2", 64'(out_rs2), 64'h3C);
    check("op_bits", 64'({out_insn30, out_insn14, out_insn12}), 64'h7);
    tick();
    #1;
    check("op_empty", 64'(out_valid), 64'd0);

    // ADDIWU immediate substitution.
    drive(1'b1, 32'hFFF0C01B, 64'h1, 64'h1234, 1'b1);
    tick();
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    check("addiwu_rs2", 64'(out_rs2), 64'hFFFFFFFFFFFFFFFF);
    check("addiwu_insn5", 64'(out_insn5), 64'd0);
    tick();

    // Rejected OP-IMM word.
    drive(1'b1, 32'h00000013, 64'h5, 64'h6, 1'b1);
    tick();
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    check("rej_illegal", 64'(illegal), 64'd1);
    check("rej_insn", 64'(illegal_insn), 64'h13);
    check("rej_valid", 64'(out_valid), 64'd0);
    tick();
    #1;
    check("rej_pulse_end", 64'(illegal), 64'd0);
    check("rej_insn_hold", 64'(illegal_insn), 64'h13);

    // Back-pressure with A, B, C.
    a_v = 64'hA; b_v = 64'hB; c_v = 64'hC;
    dut_log.delete();
    drive(1'b1, 32'h40007033, a_v, 64'd1, 1'b0); tick();
    drive(1'b1, 32'h0000703B, b_v, 64'd2, 1'b0); tick();
    drive(1'b1, 32'h40007033, c_v, 64'd3, 1'b0);
    #1;
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (last_in_fire) in_valid = 1'b0;
    end
    check("bp_count", 64'(dut_log.size()), 64'd3);
    if (dut_log.size() == 3) begin
      check("bp_first", dut_log[0], a_v);
      check("bp_second", dut_log[1], b_v);
      check("bp_third", dut_log[2], c_v);
    end

    // Streaming 100 legal words.
    n_dut_out = 0;
    rdy_low = 0;
    for (int i = 0; i < 101; i++) begin
      if (i < 100) begin
        drive(1'b1, ($urandom_range(0, 1) == 0) ? 32'h40007033 : 32'hFFF0C01B,
              {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
      end else begin
        drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
      end
      #1;
      if (!in_ready) rdy_low++;
      tick();
    end
    check("stream_count", 64'(n_dut_out), 64'd100);
    check("stream_ready_low", 64'(rdy_low), 64'd0);

    // Reset with a full buffer.
    drive(1'b1, 32'h40007033, 64'h111, 64'd0, 1'b0); tick();
    drive(1'b1, 32'h40007033, 64'h222, 64'd0, 1'b0); tick();
    reset = 1'b1;
    #1;
    check("rst_hi_in_ready", 64'(in_ready), 64'd0);
    check("rst_hi_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    check("rst_full_valid", 64'(out_valid), 64'd0);
    check("rst_full_ready", 64'(in_ready), 64'd1);
    n_dut_out = 0;
    repeat (3) tick();
    check("rst_no_ghost", 64'(n_dut_out), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, pick_insn(), {$urandom, $urandom},
            {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      tick();
    end

`ifdef RVB_ISSUE_STATS_EN
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b0);
    do_reset();
    drive(1'b1, 32'h40007033, 64'h9, 64'd0, 1'b0); tick();
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b0);
    repeat (3) tick();
    out_ready = 1'b1; tick();
    drive(1'b1, 32'h00000013, 64'd0, 64'd0, 1'b1); tick();
    drive(1'b1, 32'h00000032, 64'd0, 64'd0, 1'b1); tick();
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    check("stats_stall", 64'(stat_stall), 64'd3);
    check("stats_illegal", 64'(stat_illegal), 64'd2);
    check("stats_issued", 64'(stat_issued), 64'd1);
`else
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    do_reset();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
